// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4:1 mux select arbiter.
// Imported by the interface, the picker and the top.
package mux_arb_pkg;

  localparam int NUM_REQ      = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int GUARD_DEF    = 1;

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    GRANT
  } state_e;

  function automatic logic [NUM_REQ-1:0] to_onehot(
    input logic [1:0] i
  );
    to_onehot    = '0;
    to_onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/grant/select bundle between the arbiter and its users.
// master = arbiter side, slave = requester/mux side.
interface mux_arbiter_if;
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               s1;
  logic               s0;
  logic               valid;

  modport master (
    input  req,
    output gnt,
    output s1,
    output s0,
    output valid
  );

  modport slave (
    output req,
    input  gnt,
    input  s1,
    input  s0,
    input  valid
  );

endinterface

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit
// searching from last+1 mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               any,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  // Walk from lowest to highest priority so the
  // closest set bit after last wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin select arbiter for an external 4:1 mux,
// with guard cycles on every select change and a hold limit.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int GUARD    = GUARD_DEF
) (
  input logic           clk,
  input logic           rst,
  mux_arbiter_if.master bus
);

  localparam logic [3:0] GUARD_W  = 4'(GUARD);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         last_q, last_d;
  logic [3:0]         guard_q, guard_d;
  logic [7:0]         hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;

  logic [NUM_REQ-1:0] req;
  logic [1:0]         pick_from;
  logic [1:0]         pick_idx;
  logic               pick_any;
  logic               others;

  assign req = bus.req;

  // In GRANT the search restarts after the current owner,
  // which is the value last takes on that same edge.
  assign pick_from = (state_q == GRANT) ? sel_q : last_q;
  assign others    = |(req & ~to_onehot(sel_q));

  rr_pick u_pick (
    .req  (req),
    .last (pick_from),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    guard_d = guard_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (pick_any) begin
          sel_d   = pick_idx;
          guard_d = GUARD_W;
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (!req[sel_q]) begin
          last_d  = sel_q;
          guard_d = '0;
          state_d = IDLE;
        end else if (guard_q == 4'd1) begin
          guard_d = '0;
          hold_d  = '0;
          gnt_d   = to_onehot(sel_q);
          valid_d = 1'b1;
          state_d = GRANT;
        end else begin
          guard_d = guard_q - 4'd1;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          last_d  = sel_q;
          gnt_d   = '0;
          valid_d = 1'b0;
          hold_d  = '0;
          state_d = IDLE;
          if (pick_any) begin
            sel_d   = pick_idx;
            guard_d = GUARD_W;
            state_d = SWITCH;
          end
        end else if (hold_q == HOLD_MAX) begin
          hold_d = '0;
          if (others) begin
            last_d  = sel_q;
            sel_d   = pick_idx;
            gnt_d   = '0;
            valid_d = 1'b0;
            guard_d = GUARD_W;
            state_d = SWITCH;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      guard_q <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      guard_q <= guard_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;
  assign bus.s1    = sel_q[1];
  assign bus.s0    = sel_q[0];

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios plus random
// requests checked against a cycle-level behavioural model.
module tb_mux_arbiter;
  import mux_arb_pkg::*;

  localparam int MH    = 4;
  localparam int GD    = 1;
  localparam int BOUND = 3 * (MH + GD + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux_arbiter_if bus ();

  mux_arbiter #(
    .MAX_HOLD (MH),
    .GUARD    (GD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: who owns the mux, how many dead cycles remain,
  // how long the current tenure has run.
  int m_owner, m_last, m_dead, m_ten;
  bit m_busy, m_on;

  function automatic int rr(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_last  = 3;
    m_dead  = 0;
    m_ten   = 0;
    m_busy  = 0;
    m_on    = 0;
  endtask

  task automatic start_switch(input int w);
    m_owner = w;
    m_busy  = 1;
    m_on    = 0;
    m_dead  = GD;
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    if (!m_busy) begin
      w = rr(r, m_last);
      if (w >= 0) start_switch(w);
    end else if (!m_on) begin
      if (!r[m_owner]) begin
        m_last = m_owner;
        m_busy = 0;
      end else begin
        m_dead--;
        if (m_dead == 0) begin
          m_on  = 1;
          m_ten = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_last = m_owner;
      w      = rr(r, m_owner);
      if (w >= 0) start_switch(w);
      else begin
        m_busy = 0;
        m_on   = 0;
      end
    end else if (m_ten == MH) begin
      if ((r & ~(4'b1 << m_owner)) != 4'b0) begin
        m_last = m_owner;
        start_switch(rr(r, m_owner));
      end else m_ten = 1;
    end else m_ten++;
  endtask

  int   wt[4];
  int   max_wait = 0;
  logic prev_valid = 1'b0;
  logic [1:0] prev_sel = 2'd0;

  function automatic logic [1:0] sel_now();
    return {bus.s1, bus.s0};
  endfunction

  task automatic cycle(input logic [3:0] r);
    logic [3:0] eg;
    bus.req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    eg = m_on ? 4'(1 << m_owner) : 4'b0;
    chk("gnt",   8'(bus.gnt),   8'(eg));
    chk("valid", 8'(bus.valid), 8'(m_on));
    chk("sel",   8'(sel_now()), 8'(m_owner));
    chk("onehot", 8'($onehot0(bus.gnt)), 8'd1);
    chk("valid_or", 8'(bus.valid), 8'(|bus.gnt));
    if (prev_valid && bus.valid)
      chk("sel_stable", 8'(sel_now()), 8'(prev_sel));
    prev_valid = bus.valid;
    prev_sel   = sel_now();
    for (int i = 0; i < 4; i++) begin
      if (r[i] && !bus.gnt[i]) wt[i]++;
      else wt[i] = 0;
      if (wt[i] > max_wait) max_wait = wt[i];
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 4'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt",   8'(bus.gnt),   8'd0);
    chk("rst_valid", 8'(bus.valid), 8'd0);
    chk("rst_sel",   8'(sel_now()), 8'd0);
    rst = 1'b0;
    model_reset();
    prev_valid = 1'b0;
    prev_sel   = 2'd0;
    for (int i = 0; i < 4; i++) wt[i] = 0;
  endtask

  initial begin
    logic [3:0] rq;
    logic [3:0] eg;
    int         ph;
    bus.req = 4'b0;
    model_reset();

    // single requester, GUARD+1 latency then release
    do_reset();
    cycle(4'b0001);
    chk("lat_e1", 8'(bus.gnt), 8'd0);
    cycle(4'b0001);
    chk("lat_e2_gnt", 8'(bus.gnt), 8'h01);
    chk("lat_e2_val", 8'(bus.valid), 8'd1);
    chk("lat_e2_sel", 8'(sel_now()), 8'd0);
    cycle(4'b0000);
    chk("drop_gnt", 8'(bus.gnt), 8'd0);

    // all requesting: 4-cycle tenures, one dead cycle apart
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      cycle(4'b1111);
      eg = 4'b0;
      if (k >= 2) begin
        ph = (k - 2) % 5;
        if (ph < 4) eg = 4'(1 << (((k - 2) / 5) % 4));
      end
      chk("rr_1111", 8'(bus.gnt), 8'(eg));
    end

    // lone requester is never preempted
    do_reset();
    ph = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle(4'b0100);
      if (bus.valid) ph++;
    end
    chk("lone_valid_cycles", 8'(ph), 8'd19);
    chk("lone_gnt", 8'(bus.gnt), 8'h04);

    // abort during SWITCH, then pointer moved past 1
    do_reset();
    cycle(4'b0010);
    chk("abort_sel", 8'(sel_now()), 8'd1);
    cycle(4'b0000);
    chk("abort_gnt", 8'(bus.gnt), 8'd0);
    cycle(4'b0011);
    chk("after_abort_sel", 8'(sel_now()), 8'd0);
    cycle(4'b0011);
    chk("after_abort_gnt", 8'(bus.gnt), 8'h01);

    // asynchronous reset while granted
    do_reset();
    cycle(4'b1000);
    cycle(4'b1000);
    chk("pre_rst_gnt", 8'(bus.gnt), 8'h08);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt",   8'(bus.gnt),   8'd0);
    chk("arst_valid", 8'(bus.valid), 8'd0);
    chk("arst_sel",   8'(sel_now()), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    prev_valid = 1'b0;
    for (int i = 0; i < 4; i++) wt[i] = 0;

    // random sticky requests
    do_reset();
    rq = 4'b0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) rq[i] = ~rq[i];
      cycle(rq);
    end
    chk("starve_max", 8'(max_wait <= BOUND), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL be the maximum consecutive GRANT cycles while another requester waits; legal range 2..255.
REQ-002 Parameter GUARD, default 1, SHALL be the number of dead cycles between a select change and grant; legal range 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req  input  4  SHALL carry the requests; bit i is data source i, with a=0, b=1, c=2, d=3 of the 4:1 mux.
REQ-006 gnt  output 4  SHALL be the one-hot grant, or all zero.
REQ-007 s1, s0  output 1 each  SHALL drive the mux selects; {s1,s0} = index of the selected source.
REQ-008 valid  output 1  SHALL assert when the mux output reflects the granted source.

Function
REQ-009 FSM states SHALL be IDLE, SWITCH and GRANT; all outputs SHALL be registered.
REQ-010 Arbitration SHALL be round-robin: search order starts at last+1 mod 4, where last is the most recently granted (or aborted) index.
REQ-011 IDLE: gnt=0, valid=0, selects hold; if any req bit is set, load the winner into {s1,s0}, load the guard counter with GUARD, go to SWITCH.
REQ-012 SWITCH: gnt=0, valid=0; decrement the guard counter each cycle; at zero go to GRANT with gnt[cur]=1, valid=1, hold counter=0.
REQ-013 SWITCH abort: if req[cur] drops during SWITCH, set last=cur and return to IDLE on the next edge with no grant issued.
REQ-014 GRANT: gnt[cur] and valid SHALL stay high; the hold counter SHALL increment each cycle, saturating at MAX_HOLD-1.
REQ-015 GRANT release: if req[cur]=0, set last=cur; go to SWITCH with the next winner if another req is set, else to IDLE; gnt and valid drop on the same edge.
REQ-016 GRANT preemption: if the hold counter = MAX_HOLD-1 and any other req is set, set last=cur and go to SWITCH with the next winner.
REQ-017 If the hold counter = MAX_HOLD-1 and no other req is set, the grant SHALL continue and the hold counter SHALL reset to 0.
REQ-018 Latency: req sampled in IDLE SHALL give gnt/valid exactly GUARD+1 edges later.
REQ-019 Simultaneous release and new requests SHALL resolve in one edge using the updated last pointer.
REQ-020 {s1,s0} SHALL change only on the IDLE→SWITCH or GRANT→SWITCH edge, never while valid=1.
REQ-021 gnt SHALL never have more than one bit set, and valid SHALL equal |gnt.
REQ-022 A requester continuously requesting SHALL be granted within 3*(MAX_HOLD+GUARD+1) cycles.

Reset
REQ-023 While rst is high: state=IDLE, gnt=0000, valid=0, {s1,s0}=00, last=3, counters=0.
REQ-024 Reset assertion mid-GRANT or mid-SWITCH SHALL clear all outputs immediately, without waiting for a clock edge.
REQ-025 After reset deassertion, the first arbitration SHALL favour req[0].

Structure
REQ-026 Package mux_arb_pkg SHALL hold the state enum, the NUM_REQ=4 constant and the MAX_HOLD and GUARD defaults.
REQ-027 Sub-module rr_pick SHALL be a combinational round-robin picker: inputs req[3:0] and last[1:0]; outputs any and idx[1:0].
REQ-028 The mux datapath SHALL stay external; this block drives only the selects, gnt and valid.

Verification
REQ-029 Reset, then req=0001 → gnt=0001, valid=1, {s1,s0}=00 at the second edge (GUARD=1); drop req → gnt=0 the next edge.
REQ-030 req=1111 held, MAX_HOLD=4 → grant order 0,1,2,3,0; each GRANT is 4 cycles with 1 dead cycle between.
REQ-031 req=0100 alone for 20 cycles → gnt=0100 held throughout, valid never drops.
REQ-032 req=0010 then drop during SWITCH → no gnt pulse; FSM back in IDLE; a following req=0011 grants index 0 first.
REQ-033 rst pulse mid-GRANT (gnt=1000) → gnt=0000, valid=0, {s1,s0}=00 asynchronously.
REQ-034 Random req for 10k cycles → assertions hold: one-hot gnt, selects stable while valid, starvation bound (REQ-022) met.
